sha256_msg_pad: RTL and testbench
=================================

Name: sha256_msg_pad

Overview:
- Upstream feeder for the SHA-256 hash core.
- Reads NUM_OF_WORDS 32-bit message words from word-addressed synchronous memory and appends standard SHA-256 padding: 0x80000000 marker, zero fill, 64-bit bit-length.
- Streams the resulting 512-bit blocks one word at a time over a valid/ready interface, so the core no longer needs to buffer the whole message or hard-code padding.

Parameters:
- NUM_OF_WORDS, 20, message length in 32-bit words; legal range 0..1023.
- ADDR_W, 16, memory word-address width.

Ports:
- clk  in  1  single clock; also drives mem_clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a message; sampled only in IDLE.
- message_addr  in  ADDR_W  word address of message word 0; captured on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word handshakes.
- mem_clk  out  1  equals clk.
- mem_we  out  1  constant 0; block is read-only.
- mem_addr  out  ADDR_W  read address.
- mem_read_data  in  32  read data, valid exactly one cycle after the address is driven.
- blk_word  out  32  current stream word.
- blk_valid  out  1  blk_word is valid.
- blk_ready  in  1  consumer accepts the word; a handshake is blk_valid & blk_ready at posedge.
- blk_idx  out  4  word index within the current block, 0..15.
- blk_last  out  1  high when blk_idx == 15.
- msg_last  out  1  high for all words of the final block.

Behaviour:
- Reset values: busy=0, done=0, blk_valid=0, blk_word=0, blk_idx=0, blk_last=0, msg_last=0, mem_addr=0, mem_we=0. FSM goes to IDLE.
- Reset asserted mid-message aborts the stream immediately. No done pulse.
- Block count NB = ceil((NUM_OF_WORDS+3)/16), a compile-time constant.
- Global word index g = blk_cnt*16 + blk_idx. Source of each emitted word:
  - g < N: memory word at message_addr+g.
  - g == N: 0x80000000.
  - g == 16*NB-2: upper 32 bits of the bit length N*32.
  - g == 16*NB-1: lower 32 bits of N*32.
  - otherwise: 0.
- mem_addr = message_addr + g, computed in ADDR_W bits and wrapping modulo 2^ADDR_W.
- FSM states:
  - IDLE: busy=0. On start, capture message_addr, clear counters, go to FETCH if N>0, else go to EMIT.
  - FETCH: drive mem_addr for g, then go to CAPTURE.
  - CAPTURE: register mem_read_data into blk_word, then go to EMIT.
  - EMIT: blk_valid=1. blk_word, blk_idx, blk_last and msg_last stay stable until handshake.
    - On handshake, increment blk_idx; on wrap 15→0, increment blk_cnt.
    - If this was the last word (msg_last & blk_last): go to DONE.
    - Else if next g < N: go to FETCH.
    - Else: load the next padding/length word and stay in EMIT with blk_valid held high.
  - DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Latency:
  - Start accepted at cycle 0; first blk_valid at cycle 3.
  - Message words: 3 cycles per word with blk_ready held high.
  - Padding words: 1 word per cycle.
- blk_valid must not drop without a handshake.
- start is ignored while busy or in DONE.
- A new start is accepted in the IDLE cycle immediately after DONE.

Optional Feature:
- Macro: SHA_PAD_BYTESWAP_EN.
- Defined: memory-sourced words are byte-reversed before emission (0x11223344 becomes 0x44332211). Marker, zero and length words are unaffected.
- Undefined: memory words pass through unchanged.
- Timing is identical either way.

Test Plan:
- N=20, memory[0x100+k]=k+1, blk_ready=1, start with message_addr=0x100:
  - 32 words, msg_last set on words 16-31.
  - Block 0 = 1..16.
  - Block 1 = 17,18,19,20,0x80000000, nine zeros, 0x00000000, 0x00000280.
  - done pulses once.
- N=13 (single block): word13=0x80000000, word14=0, word15=0x000001A0, msg_last on all 16 words, blk_last only on word15.
- N=14 (boundary):
  - NB=2; block0 word14=0x80000000, word15=0.
  - Block1 words 0-14 = 0, word15=0x000001C0.
- Backpressure: N=20, blk_ready toggles pseudo-randomly → identical word sequence to the first scenario; blk_word stable while valid&!ready; no word lost or duplicated.
- Reset mid-stream: assert reset after 5 handshakes → all outputs at reset values next cycle. Restart with start → full correct sequence from word 0.
- Address wrap and ignored start: message_addr=0xFFFE, N=20 → mem_addr sequence 0xFFFE, 0xFFFF, 0x0000, …; start pulses while busy are ignored.

Source files
------------

// File: rtl/sha256_msg_pad.sv
// sha256_msg_pad: reads NUM_OF_WORDS 32-bit message words from a synchronous
// word-addressed memory and appends SHA-256 padding (0x80000000 marker, zero
// fill, 64-bit bit length). The padded blocks go out one word at a time over
// a valid/ready stream.
// Optional build macro SHA_PAD_BYTESWAP_EN: when defined, memory-sourced words
// are byte-reversed before emission. Marker, zero and length words are never
// swapped. Timing is the same in both builds.
module sha256_msg_pad #(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic [31:0]       blk_word,
  output logic              blk_valid,
  input  logic              blk_ready,
  output logic [3:0]        blk_idx,
  output logic              blk_last,
  output logic              msg_last
);

  // Block count is a compile-time constant; at most 65 blocks for N <= 1023,
  // so the global word index {blk_cnt, blk_idx} fits in 11 bits.
  localparam int G_W = 11;
  localparam int NB  = (NUM_OF_WORDS + 3 + 15) / 16;

  localparam logic [G_W-1:0] N_G      = G_W'(NUM_OF_WORDS);
  localparam logic [G_W-1:0] LEN_HI_G = G_W'(16 * NB - 2);
  localparam logic [G_W-1:0] LEN_LO_G = G_W'(16 * NB - 1);
  localparam logic [63:0]    LEN_BITS = 64'(NUM_OF_WORDS) * 64'd32;
  localparam logic [6:0]     LAST_BLK = 7'(NB - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] base_addr;
  logic [6:0]        blk_cnt;
  logic [3:0]        idx_r;
  logic [31:0]       word_r;
  logic [G_W-1:0]    g;
  logic [G_W-1:0]    g_next;
  logic              is_last;

  // Padding / length word for a global index at or beyond the message end.
  function automatic logic [31:0] pad_word(input logic [G_W-1:0] gi);
    if (gi == N_G)           return 32'h8000_0000;
    else if (gi == LEN_HI_G) return LEN_BITS[63:32];
    else if (gi == LEN_LO_G) return LEN_BITS[31:0];
    else                     return 32'h0000_0000;
  endfunction

  // Word ordering applied to memory-sourced words only.
  function automatic logic [31:0] mem_word(input logic [31:0] d);
`ifdef SHA_PAD_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  assign g       = {blk_cnt, idx_r};
  assign g_next  = g + 1'b1;
  assign is_last = msg_last & blk_last;

  // Sequencer: fetch/capture/emit for message words, one-per-cycle padding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      base_addr <= '0;
      blk_cnt   <= '0;
      idx_r     <= '0;
      word_r    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            base_addr <= message_addr;
            blk_cnt   <= '0;
            idx_r     <= '0;
            if (N_G != '0) begin
              state <= S_FETCH;
            end else begin
              word_r <= pad_word('0);
              state  <= S_EMIT;
            end
          end
        end
        S_FETCH: state <= S_CAPTURE;
        S_CAPTURE: begin
          word_r <= mem_word(mem_read_data);
          state  <= S_EMIT;
        end
        S_EMIT: begin
          if (blk_ready) begin
            {blk_cnt, idx_r} <= g_next;
            if (is_last) begin
              state <= S_DONE;
            end else if (g_next < N_G) begin
              state <= S_FETCH;
            end else begin
              word_r <= pad_word(g_next);
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory address tracks the current global index, wrapping in ADDR_W bits.
  assign mem_addr  = base_addr + ADDR_W'(g);
  assign mem_clk   = clk;
  assign mem_we    = 1'b0;

  assign busy      = (state == S_FETCH) || (state == S_CAPTURE) || (state == S_EMIT);
  assign done      = (state == S_DONE);
  assign blk_valid = (state == S_EMIT);
  assign blk_word  = word_r;
  assign blk_idx   = idx_r;
  assign blk_last  = (idx_r == 4'd15);
  assign msg_last  = (state != S_IDLE) && (blk_cnt == LAST_BLK);

endmodule

// File: tb/tb_sha256_msg_pad.sv
// tb_sha256_msg_pad: scoreboard bench for sha256_msg_pad. Three instances
// (N=20, 13, 14) share clock and reset; each has its own memory model.
module tb_sha256_msg_pad;

  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start        [NI];
  logic [15:0] message_addr [NI];
  logic        busy         [NI];
  logic        done         [NI];
  logic        mem_clk      [NI];
  logic        mem_we       [NI];
  logic [15:0] mem_addr     [NI];
  logic [31:0] mem_read_data[NI];
  logic [31:0] blk_word     [NI];
  logic        blk_valid    [NI];
  logic        blk_ready    [NI];
  logic [3:0]  blk_idx      [NI];
  logic        blk_last     [NI];
  logic        msg_last     [NI];

  typedef struct {
    logic [31:0] word;
    logic [3:0]  idx;
    logic        blast;
    logic        mlast;
    logic        is_msg;
    logic [15:0] addr;
  } exp_t;

  exp_t exp_q [NI][$];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt [NI] = '{default: 0};
  int   hs_cnt   [NI] = '{default: 0};
  bit   rand_rdy [NI] = '{default: 1'b0};
  time  t_acc;

  function automatic int nw(input int i);
    case (i)
      0:       return 20;
      1:       return 13;
      default: return 14;
    endcase
  endfunction

  // Memory contents: word at 0x100+k holds k+1.
  function automatic logic [31:0] memf(input logic [15:0] a);
    logic [15:0] d;
    d = a - 16'h0100 + 16'h0001;
    return {16'h0000, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    sha256_msg_pad #(
      .NUM_OF_WORDS(gi == 0 ? 20 : (gi == 1 ? 13 : 14)),
      .ADDR_W(16)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start[gi]),
      .message_addr (message_addr[gi]),
      .busy         (busy[gi]),
      .done         (done[gi]),
      .mem_clk      (mem_clk[gi]),
      .mem_we       (mem_we[gi]),
      .mem_addr     (mem_addr[gi]),
      .mem_read_data(mem_read_data[gi]),
      .blk_word     (blk_word[gi]),
      .blk_valid    (blk_valid[gi]),
      .blk_ready    (blk_ready[gi]),
      .blk_idx      (blk_idx[gi]),
      .blk_last     (blk_last[gi]),
      .msg_last     (msg_last[gi])
    );

    always @(posedge clk) mem_read_data[gi] <= memf(mem_addr[gi]);

    logic        hold_vld = 1'b0;
    logic [31:0] hold_word;
    logic [3:0]  hold_idx;

    // Monitor: stability under backpressure, then pop/compare on handshake.
    always @(negedge clk) begin
      if (done[gi]) done_cnt[gi]++;
      if (!reset && hold_vld) begin
        chk("valid_held", 32'(blk_valid[gi]), 32'd1);
        chk("stable_word", blk_word[gi], hold_word);
        chk("stable_idx", 32'(blk_idx[gi]), 32'(hold_idx));
      end
      if (!reset && blk_valid[gi] && blk_ready[gi]) begin
        hs_cnt[gi]++;
        if (exp_q[gi].size() == 0) begin
          chk("extra_word", 32'(blk_valid[gi]), 32'd0);
        end else begin
          exp_t e;
          e = exp_q[gi].pop_front();
          chk("word", blk_word[gi], e.word);
          chk("blk_idx", 32'(blk_idx[gi]), 32'(e.idx));
          chk("blk_last", 32'(blk_last[gi]), 32'(e.blast));
          chk("msg_last", 32'(msg_last[gi]), 32'(e.mlast));
          if (e.is_msg) chk("mem_addr", 32'(mem_addr[gi]), 32'(e.addr));
        end
      end
      hold_vld  = !reset && blk_valid[gi] && !blk_ready[gi];
      hold_word = blk_word[gi];
      hold_idx  = blk_idx[gi];
    end
  end

  // Ready driver: held high unless pseudo-random mode is selected.
  initial begin
    for (int i = 0; i < NI; i++) blk_ready[i] = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++)
        blk_ready[i] = rand_rdy[i] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_msg(input int i, input logic [15:0] base);
    int          n;
    int          nb;
    logic [63:0] len;
    exp_t        e;
    n   = nw(i);
    nb  = (n + 18) / 16;
    len = 64'(n) * 64'd32;
    for (int g = 0; g < 16 * nb; g++) begin
      if (g < n)                e.word = memf(base + 16'(g));
      else if (g == n)          e.word = 32'h8000_0000;
      else if (g == 16 * nb - 2) e.word = len[63:32];
      else if (g == 16 * nb - 1) e.word = len[31:0];
      else                      e.word = 32'h0;
      e.idx    = 4'(g % 16);
      e.blast  = (g % 16) == 15;
      e.mlast  = g >= 16 * (nb - 1);
      e.is_msg = g < n;
      e.addr   = base + 16'(g);
      exp_q[i].push_back(e);
    end
  endtask

  task automatic check_reset(input int i);
    chk("rst_busy", 32'(busy[i]), 32'd0);
    chk("rst_done", 32'(done[i]), 32'd0);
    chk("rst_valid", 32'(blk_valid[i]), 32'd0);
    chk("rst_word", blk_word[i], 32'd0);
    chk("rst_idx", 32'(blk_idx[i]), 32'd0);
    chk("rst_blk_last", 32'(blk_last[i]), 32'd0);
    chk("rst_msg_last", 32'(msg_last[i]), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr[i]), 32'd0);
    chk("rst_mem_we", 32'(mem_we[i]), 32'd0);
  endtask

  // Issue a start, then confirm first valid appears three cycles later.
  task automatic start_msg(input int i, input logic [15:0] base);
    push_msg(i, base);
    @(posedge clk);
    #1;
    start[i]        = 1'b1;
    message_addr[i] = base;
    @(posedge clk);
    t_acc = $time;
    #1;
    start[i] = 1'b0;
    @(negedge clk);
    chk("busy_c1", 32'(busy[i]), 32'd1);
    chk("valid_c1", 32'(blk_valid[i]), 32'd0);
    @(negedge clk);
    chk("valid_c2", 32'(blk_valid[i]), 32'd0);
    @(negedge clk);
    chk("valid_c3", 32'(blk_valid[i]), 32'd1);
  endtask

  task automatic wait_done(input int i, input bit lat, input int d0);
    int n;
    int nb;
    int it;
    n  = nw(i);
    nb = (n + 18) / 16;
    it = 0;
    while (!done[i] && it < 4000) begin
      @(negedge clk);
      it++;
    end
    if (!done[i]) begin
      chk("done_timeout", 32'(done[i]), 32'd1);
    end else if (lat) begin
      chk("done_latency", 32'(($time - t_acc - 5) / 10), 32'(3 * n + 16 * nb - n));
    end
    @(negedge clk);
    chk("done_pulse", 32'(done[i]), 32'd0);
    chk("busy_after", 32'(busy[i]), 32'd0);
    repeat (2) @(negedge clk);
    chk("busy_idle", 32'(busy[i]), 32'd0);
    chk("words_left", 32'(exp_q[i].size()), 32'd0);
    chk("done_count", 32'(done_cnt[i] - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int h0;
    int it;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start[i]        = 1'b0;
      message_addr[i] = 16'h0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) check_reset(i);
    @(posedge clk);
    #1 reset = 1'b0;

    // N=20 streaming with ready held high
    d0 = done_cnt[0];
    start_msg(0, 16'h0100);
    wait_done(0, 1'b1, d0);

    // N=13 single block, N=14 boundary
    d0 = done_cnt[1];
    start_msg(1, 16'h0100);
    wait_done(1, 1'b1, d0);
    d0 = done_cnt[2];
    start_msg(2, 16'h0200);
    wait_done(2, 1'b1, d0);

    // Backpressure
    rand_rdy[0] = 1'b1;
    d0 = done_cnt[0];
    start_msg(0, 16'h0100);
    wait_done(0, 1'b0, d0);
    rand_rdy[0] = 1'b0;

    // Reset after five handshakes, then a full restart
    d0 = done_cnt[0];
    h0 = hs_cnt[0];
    start_msg(0, 16'h0100);
    it = 0;
    while (hs_cnt[0] - h0 < 5 && it < 200) begin
      @(negedge clk);
      it++;
    end
    chk("hs_reached", 32'(hs_cnt[0] - h0), 32'd5);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset(0);
    exp_q[0].delete();
    repeat (2) @(negedge clk);
    chk("no_done_on_abort", 32'(done_cnt[0] - d0), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    d0 = done_cnt[0];
    start_msg(0, 16'h0100);
    wait_done(0, 1'b1, d0);

    // Address wrap with start pulses while busy
    d0 = done_cnt[0];
    start_msg(0, 16'hFFFE);
    for (int k = 0; k < 3; k++) begin
      repeat (9) @(posedge clk);
      #1;
      start[0]        = 1'b1;
      message_addr[0] = 16'h0000;
      @(negedge clk);
      chk("busy_ign", 32'(busy[0]), 32'd1);
      @(posedge clk);
      #1 start[0] = 1'b0;
    end
    wait_done(0, 1'b1, d0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
